// File: rtl/video_timing_decoder.sv
`default_nettype none
// ============================================================================
// video_timing_decoder: recovers pixel coordinates, frame markers, line/frame
// totals and a format lock indication from a raw DE/HSYNC/VSYNC video stream.
// Revision: 1.0
// ============================================================================
module video_timing_decoder #(
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                      I_PCLK,
  input  logic                      I_RST_N,
  input  logic [23:0]               I_PIX_DATA,
  input  logic                      I_VSYNC,
  input  logic                      I_HSYNC,
  input  logic                      I_DE,
  output logic [23:0]               O_PIX_DATA,
  output logic                      O_PIX_VALID,
  output logic [$clog2(H_ACT)-1:0]  O_COL,
  output logic [$clog2(V_ACT)-1:0]  O_ROW,
  output logic                      O_SOF,
  output logic                      O_EOL,
  output logic                      O_EOF,
  output logic                      O_LOCKED,
  output logic                      O_ERR,
  output logic [11:0]               O_HTOTAL,
  output logic [11:0]               O_VTOTAL
);

  localparam int COL_W     = $clog2(H_ACT);
  localparam int ROW_W     = $clog2(V_ACT);
  localparam int COL_CNT_W = $clog2(H_ACT + 2);
  localparam int ROW_CNT_W = $clog2(V_ACT + 1);

  localparam logic [COL_CNT_W-1:0] C_H_ACT  = COL_CNT_W'(H_ACT);
  localparam logic [COL_CNT_W-1:0] C_H_LAST = COL_CNT_W'(H_ACT - 1);
  localparam logic [COL_CNT_W-1:0] C_H_SAT  = COL_CNT_W'(H_ACT + 1);
  localparam logic [ROW_CNT_W-1:0] C_V_ACT  = ROW_CNT_W'(V_ACT);
  localparam logic [ROW_CNT_W-1:0] C_V_LAST = ROW_CNT_W'(V_ACT - 1);
  localparam logic [3:0]           C_LOCK   = 4'(LOCK_FRAMES);
  localparam logic [11:0]          C_SAT12  = 12'hFFF;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             good_cnt_q, good_cnt_d;
  logic                   vs_prev_q, hs_prev_q, de_prev_q;
  logic [COL_CNT_W-1:0]   col_cnt_q, col_cnt_d;
  logic [ROW_CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [11:0]            h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0]            htotal_q, htotal_d, vtotal_q, vtotal_d;
  logic [11:0]            h_inc, v_inc;
  logic [23:0]            pix_data_q;
  logic                   pix_valid_q, pix_valid_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic                   locked_q, locked_d, err_q, err_d;

  logic vs_edge, hs_edge, de_rise, de_fall;
  logic line_err, row_ovf, frame_err;

  // Active edge: input now at the active level, previous sample was not.
  assign vs_edge  = (I_VSYNC == VS_POL) && (vs_prev_q != VS_POL);
  assign hs_edge  = (I_HSYNC == HS_POL) && (hs_prev_q != HS_POL);
  assign de_rise  = I_DE && !de_prev_q;
  assign de_fall  = !I_DE && de_prev_q;

  assign line_err  = de_fall && (col_cnt_q != C_H_ACT);
  assign row_ovf   = de_rise && (row_cnt_q == C_V_ACT);
  assign frame_err = vs_edge && (row_cnt_q != C_V_ACT) && (state_q != ST_SEARCH);

  always_comb begin
    col_cnt_d   = '0;
    row_cnt_d   = row_cnt_q;
    pix_valid_d = I_DE && (col_cnt_q < C_H_ACT) && (row_cnt_q < C_V_ACT);
    col_d       = COL_W'(col_cnt_q);
    row_d       = ROW_W'(row_cnt_q);
    sof_d       = pix_valid_d && (col_cnt_q == '0) && (row_cnt_q == '0);
    eol_d       = pix_valid_d && (col_cnt_q == C_H_LAST);
    eof_d       = eol_d && (row_cnt_q == C_V_LAST);
    err_d       = line_err || row_ovf || frame_err;

    if (I_DE) begin
      col_cnt_d = (col_cnt_q == C_H_SAT) ? col_cnt_q : col_cnt_q + 1'b1;
    end
    if (vs_edge) begin
      row_cnt_d = '0;
    end else if (de_fall && (row_cnt_q != C_V_ACT)) begin
      row_cnt_d = row_cnt_q + 1'b1;
    end

    h_inc    = (h_cnt_q == C_SAT12) ? h_cnt_q : h_cnt_q + 12'd1;
    v_inc    = (v_cnt_q == C_SAT12) ? v_cnt_q : v_cnt_q + 12'd1;
    h_cnt_d  = h_inc;
    htotal_d = htotal_q;
    if (hs_edge) begin
      htotal_d = h_inc;
      h_cnt_d  = '0;
    end
    v_cnt_d  = hs_edge ? v_inc : v_cnt_q;
    vtotal_d = vtotal_q;
    // A coincident HSYNC edge belongs to the frame that starts here.
    if (vs_edge) begin
      vtotal_d = v_cnt_q;
      v_cnt_d  = hs_edge ? 12'd1 : 12'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_edge) begin
          state_d    = ST_MEASURE;
          good_cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (line_err || row_ovf) begin
          state_d = ST_SEARCH;
        end else if (vs_edge) begin
          // A short/long frame restarts the good-frame count from this edge.
          if (frame_err) begin
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 >= C_LOCK) begin
              state_d = ST_LOCKED;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (err_d) begin
          state_d = ST_SEARCH;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge I_PCLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q     <= ST_SEARCH;
      good_cnt_q  <= '0;
      vs_prev_q   <= 1'b0;
      hs_prev_q   <= 1'b0;
      de_prev_q   <= 1'b0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      htotal_q    <= '0;
      vtotal_q    <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      vs_prev_q   <= I_VSYNC;
      hs_prev_q   <= I_HSYNC;
      de_prev_q   <= I_DE;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      htotal_q    <= htotal_d;
      vtotal_q    <= vtotal_d;
      pix_data_q  <= I_PIX_DATA;
      pix_valid_q <= pix_valid_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign O_PIX_DATA  = pix_data_q;
  assign O_PIX_VALID = pix_valid_q;
  assign O_COL       = col_q;
  assign O_ROW       = row_q;
  assign O_SOF       = sof_q;
  assign O_EOL       = eol_q;
  assign O_EOF       = eof_q;
  assign O_LOCKED    = locked_q;
  assign O_ERR       = err_q;
  assign O_HTOTAL    = htotal_q;
  assign O_VTOTAL    = vtotal_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_decoder.sv
`default_nettype none
// ============================================================================
// tb_video_timing_decoder: scoreboard bench on a reduced 12x7 timing
// (8x4 active) with an active-low and an active-high sync instance.
// Revision: 1.0
// ============================================================================
module tb_video_timing_decoder;

  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int H_TOT = 12;

  typedef struct packed {
    logic [23:0] data;
    logic        valid;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [2:0]  col;
    logic [1:0]  row;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pix;
  logic        vs, hs, de;

  logic [23:0] o_data, p_data;
  logic        o_valid, o_sof, o_eol, o_eof, o_locked, o_err;
  logic        p_valid, p_sof, p_eol, p_eof, p_locked, p_err;
  logic [2:0]  o_col, p_col;
  logic [1:0]  o_row, p_row;
  logic [11:0] o_htotal, o_vtotal, p_htotal, p_vtotal;

  exp_t sb[$];
  exp_t mon_e, mon_g;
  int   m_col, m_row;
  logic m_vs, m_de;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   err_cnt  = 0;

  always #5 clk = ~clk;

  video_timing_decoder #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
  ) u_dut (
    .I_PCLK(clk), .I_RST_N(rst_n), .I_PIX_DATA(pix),
    .I_VSYNC(vs), .I_HSYNC(hs), .I_DE(de),
    .O_PIX_DATA(o_data), .O_PIX_VALID(o_valid), .O_COL(o_col), .O_ROW(o_row),
    .O_SOF(o_sof), .O_EOL(o_eol), .O_EOF(o_eof), .O_LOCKED(o_locked),
    .O_ERR(o_err), .O_HTOTAL(o_htotal), .O_VTOTAL(o_vtotal)
  );

  // Same stream with inverted syncs into an active-high configured decoder.
  video_timing_decoder #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)
  ) u_dut_p (
    .I_PCLK(clk), .I_RST_N(rst_n), .I_PIX_DATA(pix),
    .I_VSYNC(~vs), .I_HSYNC(~hs), .I_DE(de),
    .O_PIX_DATA(p_data), .O_PIX_VALID(p_valid), .O_COL(p_col), .O_ROW(p_row),
    .O_SOF(p_sof), .O_EOL(p_eol), .O_EOF(p_eof), .O_LOCKED(p_locked),
    .O_ERR(p_err), .O_HTOTAL(p_htotal), .O_VTOTAL(p_vtotal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
    m_vs  = 1'b0;
    m_de  = 1'b0;
  endtask

  // Drive one pixel cycle and push the pixel-path result it must produce.
  task automatic drive(input logic v, input logic h, input logic d_e, input logic [23:0] d);
    exp_t e;
    @(negedge clk);
    vs = v; hs = h; de = d_e; pix = d;
    e       = '0;
    e.data  = d;
    e.valid = d_e && (m_col < H_ACT) && (m_row < V_ACT);
    if (e.valid) begin
      e.col = 3'(m_col);
      e.row = 2'(m_row);
      e.sof = (m_col == 0) && (m_row == 0);
      e.eol = (m_col == H_ACT - 1);
      e.eof = e.eol && (m_row == V_ACT - 1);
    end
    sb.push_back(e);
    if (v == 1'b0 && m_vs != 1'b0) m_row = 0;
    else if (!d_e && m_de && m_row < V_ACT) m_row++;
    m_col = d_e ? ((m_col < H_ACT + 1) ? m_col + 1 : m_col) : 0;
    m_vs  = v;
    m_de  = d_e;
  endtask

  task automatic send_line(input int fr, input int ln, input int de_len,
                           input logic vs_line, input int x0, input int x1);
    for (int x = x0; x < x1; x++)
      drive(!vs_line, !(x == 9 || x == 10), x < de_len, {8'(fr), 8'(ln), 8'(x)});
  endtask

  task automatic send_frame(input int fr, input int n_act, input int short_ln);
    for (int ln = 0; ln < n_act + 3; ln++)
      send_line(fr, ln, (ln < n_act) ? ((ln == short_ln) ? H_ACT - 1 : H_ACT) : 0,
                ln == n_act + 1, 0, H_TOT);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (o_err) err_cnt++;
      if (sb.size() > 0) begin
        mon_e       = sb.pop_front();
        mon_g       = '0;
        mon_g.data  = o_data;
        mon_g.valid = o_valid;
        mon_g.sof   = o_sof;
        mon_g.eol   = o_eol;
        mon_g.eof   = o_eof;
        if (mon_e.valid) begin
          mon_g.col = o_col;
          mon_g.row = o_row;
        end
        n_checks++;
        assert (mon_g === mon_e) n_pass++;
        else $error("FAIL pix_path: observed %h expected %h", mon_g, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vs = 1'b1; hs = 1'b1; de = 1'b0; pix = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(|{o_data, o_valid, o_col, o_row, o_sof, o_eol, o_eof,
                            o_locked, o_err, o_htotal, o_vtotal}), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    send_frame(1, V_ACT, -1);
    chk("lock_f1", 32'(o_locked), 0);
    send_frame(2, V_ACT, -1);
    chk("lock_f2", 32'(o_locked), 0);
    chk("htotal", 32'(o_htotal), H_TOT);
    chk("vtotal", 32'(o_vtotal), 7);
    chk("htotal_pos", 32'(p_htotal), H_TOT);
    chk("vtotal_pos", 32'(p_vtotal), 7);
    send_frame(3, V_ACT, -1);
    chk("lock_f3", 32'(o_locked), 1);
    chk("lock_f3_pos", 32'(p_locked), 1);
    chk("err_nominal", 32'(err_cnt), 0);

    send_frame(4, V_ACT, 2);
    chk("err_short", 32'(err_cnt), 1);
    chk("lock_short", 32'(o_locked), 0);
    chk("lock_short_pos", 32'(p_locked), 0);
    send_frame(5, V_ACT, -1);
    chk("lock_f5", 32'(o_locked), 0);
    send_frame(6, V_ACT, -1);
    chk("relock_f6", 32'(o_locked), 1);

    send_frame(7, V_ACT + 1, -1);
    chk("err_extra", 32'(err_cnt), 2);
    chk("lock_extra", 32'(o_locked), 0);
    chk("vtotal_extra", 32'(o_vtotal), 8);
    send_frame(8, V_ACT, -1);
    chk("vtotal_f8", 32'(o_vtotal), 7);
    chk("lock_f8", 32'(o_locked), 0);
    send_frame(9, V_ACT, -1);
    chk("relock_f9", 32'(o_locked), 1);

    send_line(10, 0, H_ACT, 1'b0, 0, H_TOT);
    send_line(10, 1, H_ACT, 1'b0, 0, H_TOT);
    send_line(10, 2, H_ACT, 1'b0, 0, 6);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midline_reset_outs", 32'(|{o_data, o_valid, o_col, o_row, o_sof, o_eol, o_eof,
                                    o_locked, o_err, o_htotal, o_vtotal}), 0);
    chk("midline_reset_pos", 32'(|{p_locked, p_htotal, p_vtotal, p_valid}), 0);
    sb.delete();
    model_reset();
    vs = 1'b1; hs = 1'b1; de = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send_line(10, 2, H_ACT, 1'b0, 6, H_TOT);
    for (int ln = 3; ln < V_ACT + 3; ln++)
      send_line(10, ln, (ln < V_ACT) ? H_ACT : 0, ln == V_ACT + 1, 0, H_TOT);
    chk("err_after_reset", 32'(err_cnt), 3);
    chk("lock_f10", 32'(o_locked), 0);
    send_frame(11, V_ACT, -1);
    chk("lock_f11", 32'(o_locked), 0);
    send_frame(12, V_ACT, -1);
    chk("relock_f12", 32'(o_locked), 1);
    chk("relock_f12_pos", 32'(p_locked), 1);

    @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_timing_decoder.md
Name: video_timing_decoder

Overview:
Input-side counterpart of the pixel-clock video timing generator. It takes the raw incoming RGB/VSYNC/HSYNC/DE stream on the pixel clock and recovers per-pixel column/row coordinates, start-of-frame, end-of-line and end-of-frame markers. It also measures total line and frame lengths and runs a lock state machine that checks the incoming format against the configured active size. It sits between the video input pins and the colorspace converter / frame buffer write path.

Parameters:
H_ACT, 640, active pixels per line (expected DE-high run length)
V_ACT, 480, active lines per frame
HS_POL, 0, HSYNC active level (0 = active-low, VGA 640x480)
VS_POL, 0, VSYNC active level (0 = active-low)
LOCK_FRAMES, 2, consecutive good frames required to assert lock (1..15)

Ports:
I_PCLK  in  1  pixel clock, all logic on rising edge
I_RST_N  in  1  asynchronous active-low reset
I_PIX_DATA  in  24  incoming RGB pixel
I_VSYNC  in  1  incoming vertical sync
I_HSYNC  in  1  incoming horizontal sync
I_DE  in  1  incoming data enable
O_PIX_DATA  out  24  registered pixel
O_PIX_VALID  out  1  pixel/coordinates valid this cycle
O_COL  out  $clog2(H_ACT)  pixel column
O_ROW  out  $clog2(V_ACT)  pixel row
O_SOF  out  1  first valid pixel of frame (row 0, col 0)
O_EOL  out  1  last valid pixel of line (col H_ACT-1)
O_EOF  out  1  last valid pixel of frame (row V_ACT-1, col H_ACT-1)
O_LOCKED  out  1  format locked
O_ERR  out  1  one-cycle pulse on any format violation
O_HTOTAL  out  12  measured PCLKs between HSYNC active edges
O_VTOTAL  out  12  measured HSYNC active edges between VSYNC active edges

Behaviour:
- Single clock domain: I_PCLK. Reset is asynchronous and active-low (I_RST_N). All outputs reset to 0. Internal counters reset to 0. FSM resets to SEARCH.
- Previous-cycle copies of VSYNC, HSYNC and DE are held internally for edge detection. Active edge = transition into the level set by the *_POL parameter.
- Latency: 1 PCLK. Input at edge N appears on O_PIX_DATA, O_PIX_VALID, O_COL and O_ROW after edge N+1. O_PIX_DATA follows I_PIX_DATA every cycle, whether or not DE is high.
- Column counter col_cnt (counts up to H_ACT+1, saturating):
  - cleared on DE low
  - incremented on each DE-high cycle
  - O_COL = col_cnt value before the increment
- Row counter row_cnt:
  - cleared on VSYNC active edge
  - incremented on DE falling edge, saturating at V_ACT
- O_PIX_VALID = DE && col_cnt < H_ACT && row_cnt < V_ACT, independent of lock. O_SOF, O_EOL and O_EOF are qualified by O_PIX_VALID.
- Violation checks (each produces an O_ERR pulse one cycle after detection; simultaneous violations produce a single pulse):
  - line error: DE falling edge with col_cnt != H_ACT
  - row overflow: DE rising edge with row_cnt == V_ACT
  - frame error: VSYNC active edge with row_cnt != V_ACT, except on the first VSYNC seen in SEARCH
- HTOTAL counter:
  - counts PCLKs, saturating at 4095
  - on HSYNC active edge, copies count+1 to O_HTOTAL, then restarts at 0
- VTOTAL counter:
  - counts HSYNC active edges, saturating at 4095
  - on VSYNC active edge, copies to O_VTOTAL, then restarts
  - if HSYNC and VSYNC active edges coincide, the HSYNC is counted into the new frame
- FSM:
  - SEARCH: ignore errors for lock purposes; on VSYNC active edge go to MEASURE with good_cnt = 0.
  - MEASURE: any line error or row overflow goes to SEARCH. On VSYNC active edge with no error this frame, good_cnt increments; when good_cnt reaches LOCK_FRAMES go to LOCKED.
  - LOCKED: O_LOCKED = 1. Any violation goes to SEARCH and clears O_LOCKED on the same edge that registers O_ERR.
- O_LOCKED is registered from the FSM state.
- Reset mid-frame: everything clears. Coordinates are not trusted until row_cnt has been cleared by a VSYNC edge. O_PIX_VALID may assert before that, with O_LOCKED = 0.

Test Plan:
- Nominal: 3 frames of 800x525 timing (HACT 640, VACT 480, active-low syncs) -> O_LOCKED rises at the 3rd VSYNC active edge (SEARCH + 2 good frames); O_HTOTAL = 800, O_VTOTAL = 525; O_SOF at col 0/row 0; O_EOF at col 639/row 479; exactly 307200 O_PIX_VALID cycles per frame.
- Short line: while locked, line 100 has 639 DE cycles -> one O_ERR pulse the cycle after DE falls; O_LOCKED = 0; relocks after 2 further good frames.
- Extra line: 481 active lines -> O_ERR on DE rising edge of line 481; O_PIX_VALID stays low throughout that line.
- Latency and data: ramp I_PIX_DATA = 24'h000000 + col -> O_PIX_DATA equals the input delayed exactly 1 PCLK; O_COL matches the low bits of the ramp.
- Async reset mid-line (row 200, col 300), asserted between clock edges -> all outputs 0 immediately; after release, O_LOCKED is not asserted before VSYNC edge + 2 good frames.
- Polarity: HS_POL = 1, VS_POL = 1 with inverted syncs -> same results as the nominal test; with syncs left non-inverted, O_VTOTAL/O_HTOTAL are still measured, but lock behaviour is checked against the mis-aligned edge.
